// File: rtl/m107_pkg.sv
// Shared types and defaults for the ROM port arbiter: FSM state encoding
// and refresh timing defaults.
package m107_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      REFRESH = 2'd2
   } arb_state_t;

   localparam logic [9:0] REFRESH_LIMIT_DEFAULT = 10'd512;
   localparam logic [2:0] REFRESH_HOLD_DEFAULT  = 3'd4;
   localparam logic [9:0] REFRESH_CNT_MAX       = 10'h3FF;

endpackage

// File: rtl/rom_port_arbiter.sv
// Two-client toggle-handshake arbiter in front of an SDRAM read port, with
// forced and opportunistic refresh scheduling.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transfer open; pick forced refresh, a client, or a hinted refresh
// BUSY    | one downstream read outstanding for grant_idx
// REFRESH | refresh strobe issued; port blocked for REFRESH_HOLD cycles
module rom_port_arbiter
   import m107_pkg::*;
#(
   parameter logic [9:0] REFRESH_LIMIT = REFRESH_LIMIT_DEFAULT,
   parameter logic [2:0] REFRESH_HOLD  = REFRESH_HOLD_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        c0_req,
   output logic        c0_ack,
   input  logic [24:0] c0_addr,
   output logic [63:0] c0_data,
   input  logic        c1_req,
   output logic        c1_ack,
   input  logic [24:0] c1_addr,
   output logic [63:0] c1_data,
   input  logic        refresh_hint,
   output logic        sdr_req,
   input  logic        sdr_ack,
   output logic [24:0] sdr_addr,
   input  logic [63:0] sdr_data,
   output logic        sdr_refresh
);

   arb_state_t state;
   logic [9:0] refresh_cnt;
   logic [2:0] hold_cnt;
   logic       last_grant;
   logic       grant_idx;

   logic c0_pending;
   logic c1_pending;
   logic any_pending;
   logic xfer_done;
   logic force_refresh;
   logic grant_sel;

   assign c0_pending    = (c0_req != c0_ack);
   assign c1_pending    = (c1_req != c1_ack);
   assign any_pending   = c0_pending | c1_pending;
   assign xfer_done     = (sdr_req == sdr_ack);
   assign force_refresh = (refresh_cnt >= REFRESH_LIMIT);

   // Round-robin: on contention the channel that did not win last time goes.
   always_comb begin
      grant_sel = 1'b0;
      if (c0_pending && c1_pending) begin
         grant_sel = ~last_grant;
      end else if (c1_pending) begin
         grant_sel = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         sdr_req     <= 1'b0;
         c0_ack      <= 1'b0;
         c1_ack      <= 1'b0;
         sdr_addr    <= '0;
         c0_data     <= '0;
         c1_data     <= '0;
         sdr_refresh <= 1'b0;
         refresh_cnt <= '0;
         hold_cnt    <= '0;
         last_grant  <= 1'b1;
         grant_idx   <= 1'b0;
      end else begin
         sdr_refresh <= 1'b0;
         if (state != REFRESH && refresh_cnt != REFRESH_CNT_MAX) begin
            refresh_cnt <= refresh_cnt + 10'd1;
         end

         case (state)
            IDLE: begin
               if (force_refresh || (!any_pending && refresh_hint)) begin
                  state       <= REFRESH;
                  sdr_refresh <= 1'b1;
                  refresh_cnt <= '0;
                  hold_cnt    <= REFRESH_HOLD - 3'd1;
               end else if (any_pending) begin
                  state     <= BUSY;
                  grant_idx <= grant_sel;
                  sdr_addr  <= grant_sel ? c1_addr : c0_addr;
                  sdr_req   <= ~sdr_req;
               end
            end

            BUSY: begin
               if (xfer_done) begin
                  if (grant_idx) begin
                     c1_data <= sdr_data;
                     c1_ack  <= ~c1_ack;
                  end else begin
                     c0_data <= sdr_data;
                     c0_ack  <= ~c0_ack;
                  end
                  last_grant <= grant_idx;
                  state      <= IDLE;
               end
            end

            REFRESH: begin
               if (hold_cnt == 3'd0) begin
                  state <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt - 3'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed plus randomized bench for rom_port_arbiter with a behavioural
// SDRAM responder and a transaction-level grant-order model.
module tb_rom_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        c0_req = 1'b0;
   logic        c0_ack;
   logic [24:0] c0_addr = '0;
   logic [63:0] c0_data;
   logic        c1_req = 1'b0;
   logic        c1_ack;
   logic [24:0] c1_addr = '0;
   logic [63:0] c1_data;
   logic        refresh_hint = 1'b0;
   logic        sdr_req;
   logic        sdr_ack = 1'b0;
   logic [24:0] sdr_addr;
   logic [63:0] sdr_data = '0;
   logic        sdr_refresh;

   rom_port_arbiter dut (
      .clk(clk), .reset(reset),
      .c0_req(c0_req), .c0_ack(c0_ack), .c0_addr(c0_addr), .c0_data(c0_data),
      .c1_req(c1_req), .c1_ack(c1_ack), .c1_addr(c1_addr), .c1_data(c1_data),
      .refresh_hint(refresh_hint),
      .sdr_req(sdr_req), .sdr_ack(sdr_ack), .sdr_addr(sdr_addr),
      .sdr_data(sdr_data), .sdr_refresh(sdr_refresh)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   int ref_pulses = 0;
   int ref_high = 0;
   int ref_cyc = 0;
   logic prev_ref = 1'b0;
   logic last_sdr_req = 1'b0;
   int grant_cycs[$];
   logic [24:0] grant_addrs[$];

   int resp_lat = 5;
   bit resp_busy = 1'b0;
   int resp_wait = 0;
   logic [24:0] resp_addr = '0;
   int ack_cyc = 0;

   // model state
   logic model_last = 1'b1;
   logic [63:0] exp_d0 = '0;
   logic [63:0] exp_d1 = '0;

   function automatic logic [63:0] mem_word(input logic [24:0] a);
      if (a == 25'h0100040) return 64'hDEADBEEF_01234567;
      return {7'h15, a, 7'h6A, ~a};
   endfunction

   // Edge monitor: sees pre-edge values, so an event set at edge k is logged as k+1.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (sdr_refresh) begin
         ref_high = ref_high + 1;
         ref_cyc  = cyc;
         if (!prev_ref) ref_pulses = ref_pulses + 1;
      end
      prev_ref = sdr_refresh;
      if (reset) begin
         last_sdr_req = 1'b0;
      end else if (sdr_req != last_sdr_req) begin
         grant_cycs.push_back(cyc);
         grant_addrs.push_back(sdr_addr);
         last_sdr_req = sdr_req;
      end
   end

   // SDRAM responder sharing the arbiter reset.
   always @(negedge clk) begin
      if (reset) begin
         sdr_ack   = 1'b0;
         resp_busy = 1'b0;
      end else if (!resp_busy) begin
         if (sdr_req != sdr_ack) begin
            resp_busy = 1'b1;
            resp_wait = resp_lat;
            resp_addr = sdr_addr;
         end
      end else if (resp_wait > 1) begin
         resp_wait = resp_wait - 1;
      end else begin
         sdr_data  = mem_word(resp_addr);
         sdr_ack   = sdr_req;
         resp_busy = 1'b0;
         ack_cyc   = cyc;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      c0_req = 1'b0;
      c1_req = 1'b0;
      refresh_hint = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      model_last = 1'b1;
      exp_d0 = '0;
      exp_d1 = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " sdr_req"}, sdr_req, 1'b0);
      check({tag, " c0_ack"}, c0_ack, 1'b0);
      check({tag, " c1_ack"}, c1_ack, 1'b0);
      check({tag, " sdr_addr"}, sdr_addr, 25'h0);
      check({tag, " c0_data"}, c0_data, 64'h0);
      check({tag, " c1_data"}, c1_data, 64'h0);
      check({tag, " sdr_refresh"}, sdr_refresh, 1'b0);
   endtask

   task automatic wait_acks(input string tag, input int budget);
      int n = 0;
      while ((c0_ack !== c0_req || c1_ack !== c1_req) && n < budget) begin
         tick();
         n++;
      end
      check({tag, " acks settle"}, (c0_ack === c0_req && c1_ack === c1_req), 1'b1);
   endtask

   // One arbitration round: issue the selected requests together, predict order.
   task automatic run_round(input string tag, input bit r0, input bit r1,
                            input logic [24:0] a0, input logic [24:0] a1);
      logic [24:0] exp_q[$];
      int base;
      base = grant_addrs.size();
      if (r0 && r1) begin
         if (model_last) begin
            exp_q.push_back(a0); exp_q.push_back(a1); model_last = 1'b1;
         end else begin
            exp_q.push_back(a1); exp_q.push_back(a0); model_last = 1'b0;
         end
      end else if (r0) begin
         exp_q.push_back(a0); model_last = 1'b0;
      end else begin
         exp_q.push_back(a1); model_last = 1'b1;
      end
      if (r0) begin c0_addr = a0; c0_req = ~c0_req; exp_d0 = mem_word(a0); end
      if (r1) begin c1_addr = a1; c1_req = ~c1_req; exp_d1 = mem_word(a1); end
      wait_acks(tag, 200);
      check({tag, " grant count"}, grant_addrs.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i < grant_addrs.size())
            check($sformatf("%s grant%0d addr", tag, i), grant_addrs[base + i], exp_q[i]);
      end
      check({tag, " c0_data"}, c0_data, exp_d0);
      check({tag, " c1_data"}, c1_data, exp_d1);
   endtask

   initial begin
      int n;
      int base;
      int pulses0;
      int high0;
      int rel;
      int e_cyc;
      int first_after;
      logic [24:0] a0;
      logic [24:0] a1;
      int mask;

      // reset state
      do_reset();
      check_reset_outputs("reset");
      check("reset refresh_cnt", dut.refresh_cnt, 10'd0);

      // single c0 request, address change after grant must be ignored
      resp_lat = 5;
      base = grant_addrs.size();
      c0_addr = 25'h0100040;
      c0_req = ~c0_req;
      tick();
      tick();
      c0_addr = 25'h1ABCDEF;
      n = 0;
      while (c0_ack === 1'b0 && n < 50) begin tick(); n++; end
      check("single c0_ack toggled", c0_ack, 1'b1);
      check("single ack one cycle after sdr_ack", cyc, ack_cyc + 1);
      check("single c0_data", c0_data, 64'hDEADBEEF_01234567);
      check("single sdr_addr", sdr_addr, 25'h0100040);
      check("single sdr_req toggles", grant_addrs.size() - base, 1);
      check("single c1_ack", c1_ack, 1'b0);
      check("single c1_data", c1_data, 64'h0);
      model_last = 1'b0;
      exp_d0 = 64'hDEADBEEF_01234567;

      // simultaneous requests from reset alternate c0, c1 twice
      do_reset();
      resp_lat = 4;
      a0 = 25'($urandom()); a1 = 25'($urandom());
      run_round("simul1", 1'b1, 1'b1, a0, a1);
      a0 = 25'($urandom()); a1 = 25'($urandom());
      run_round("simul2", 1'b1, 1'b1, a0, a1);

      // randomized rounds against the order model
      for (int r = 0; r < 12; r++) begin
         mask = $urandom_range(1, 3);
         resp_lat = $urandom_range(1, 6);
         a0 = 25'($urandom()); a1 = 25'($urandom());
         run_round($sformatf("rand%0d", r), (mask & 1) != 0, (mask & 2) != 0, a0, a1);
      end

      // c1 cancels its own request while c0 is busy
      resp_lat = 8;
      base = grant_addrs.size();
      a0 = 25'($urandom());
      c0_addr = a0;
      c0_req = ~c0_req;
      tick();
      c1_req = ~c1_req;
      tick();
      c1_req = ~c1_req;
      wait_acks("cancel", 100);
      repeat (10) tick();
      check("cancel grant count", grant_addrs.size() - base, 1);
      check("cancel c1_ack", c1_ack, c1_req);
      check("cancel c0_data", c0_data, mem_word(a0));

      // opportunistic refresh, and a hint during BUSY is dropped
      do_reset();
      repeat (3) tick();
      pulses0 = ref_pulses;
      refresh_hint = 1'b1;
      tick();
      refresh_hint = 1'b0;
      check("hint sdr_refresh high", sdr_refresh, 1'b1);
      check("hint refresh_cnt cleared", dut.refresh_cnt, 10'd0);
      tick();
      check("hint sdr_refresh one cycle", sdr_refresh, 1'b0);
      repeat (5) tick();
      check("hint pulse count", ref_pulses - pulses0, 1);
      pulses0 = ref_pulses;
      resp_lat = 6;
      c0_addr = 25'($urandom());
      c0_req = ~c0_req;
      tick();
      tick();
      refresh_hint = 1'b1;
      tick();
      refresh_hint = 1'b0;
      wait_acks("busy hint", 50);
      repeat (5) tick();
      check("busy hint dropped", ref_pulses - pulses0, 0);

      // forced refresh under continuous c0 traffic
      do_reset();
      rel = cyc;
      resp_lat = 3;
      pulses0 = ref_pulses;
      high0 = ref_high;
      for (int i = 0; i < 600; i++) begin
         if (c0_ack === c0_req) begin
            c0_addr = 25'($urandom());
            c0_req = ~c0_req;
         end
         tick();
      end
      check("forced pulse count", ref_pulses - pulses0, 1);
      check("forced pulse width", ref_high - high0, 1);
      e_cyc = ref_cyc - 1;
      check("forced pulse timing", (e_cyc - rel >= 513) && (e_cyc - rel <= 520), 1'b1);
      first_after = 0;
      foreach (grant_cycs[i]) begin
         if (first_after == 0 && grant_cycs[i] > ref_cyc) first_after = grant_cycs[i];
      end
      check("forced grants resume after hold", first_after, ref_cyc + 5);

      // reset during a c1 transfer abandons it
      do_reset();
      resp_lat = 8;
      base = grant_addrs.size();
      c1_addr = 25'($urandom());
      c1_req = 1'b1;
      n = 0;
      while (sdr_req === 1'b0 && n < 10) begin tick(); n++; end
      check("midbusy c1 granted", sdr_req, 1'b1);
      tick();
      tick();
      reset = 1'b1;
      c1_req = 1'b0;
      tick();
      tick();
      check_reset_outputs("midbusy");
      reset = 1'b0;
      repeat (15) tick();
      check("midbusy c1_ack stays", c1_ack, 1'b0);
      check("midbusy c1_data stays", c1_data, 64'h0);
      check("midbusy no new grant", grant_addrs.size() - base, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 The module SHALL use clock clk and reset reset (synchronous, active-high).
REQ-002 Parameter REFRESH_LIMIT, default 10'd512: number of clk cycles without a refresh before a refresh is forced.
REQ-003 Parameter REFRESH_HOLD, default 3'd4: number of clk cycles the port stays blocked after a refresh pulse.
REQ-004 The ports SHALL be as follows:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- c0_req  in  1  sprite channel request toggle
- c0_ack  out  1  sprite channel acknowledge toggle
- c0_addr  in  25  sprite channel SDRAM byte address
- c0_data  out  64  sprite channel read data
- c1_req  in  1  tile channel request toggle
- c1_ack  out  1  tile channel acknowledge toggle
- c1_addr  in  25  tile channel address
- c1_data  out  64  tile channel read data
- refresh_hint  in  1  1-cycle strobe: clients are idle, refresh is welcome
- sdr_req  out  1  downstream request toggle
- sdr_ack  in  1  downstream acknowledge toggle
- sdr_addr  out  25  downstream address
- sdr_data  in  64  downstream read data
- sdr_refresh  out  1  1-cycle refresh strobe

Function
REQ-005 A channel n SHALL be pending when cn_req != cn_ack; a downstream transfer SHALL be complete when sdr_req == sdr_ack.
REQ-006 The state machine SHALL have three states, IDLE, BUSY and REFRESH, and SHALL leave reset in IDLE.
REQ-007 In IDLE, priority SHALL be:
- first, forced refresh when refresh_cnt >= REFRESH_LIMIT;
- then pending channels;
- then refresh_hint.
REQ-008 When both channels are pending in IDLE, the grant SHALL go to the channel that did not win the most recent grant (round-robin via last_grant, which resets to 1 so that c0 wins first).
REQ-009 On a grant, sdr_addr SHALL take the granted cn_addr in that cycle, sdr_req SHALL toggle, the grant index SHALL be latched, and the state SHALL go to BUSY; address changes after the grant SHALL be ignored.
REQ-010 In BUSY, on the first cycle the transfer is complete, the arbiter SHALL:
- load sdr_data into the granted cn_data;
- toggle the granted cn_ack;
- update last_grant;
- return to IDLE.
The client ack SHALL toggle exactly 1 clk after sdr_ack matches.
REQ-011 The cn_data of a non-granted channel SHALL hold its value.
REQ-012 Minimum grant-to-grant spacing SHALL be 2 cycles: a return to IDLE followed by a new grant.
REQ-013 On entering REFRESH, the arbiter SHALL:
- pulse sdr_refresh high for exactly 1 cycle;
- clear refresh_cnt;
- stay in REFRESH for REFRESH_HOLD cycles, then return to IDLE.
REQ-014 refresh_cnt SHALL be 10 bits, increment every cycle outside REFRESH, and saturate at 10'h3FF; it SHALL never wrap.
REQ-015 refresh_hint arriving while in BUSY or REFRESH SHALL be dropped, not queued.
REQ-016 A client that toggles its req twice while not granted cancels its own pending request; no transfer SHALL occur for it.
REQ-017 A forced refresh SHALL never interrupt BUSY; it SHALL wait until IDLE.

Reset
REQ-018 On reset, the following SHALL take these values:
- state = IDLE
- sdr_req = 0, c0_ack = 0, c1_ack = 0
- sdr_addr = 0, c0_data = 0, c1_data = 0
- sdr_refresh = 0
- refresh_cnt = 0, last_grant = 1
REQ-019 Reset asserted mid-BUSY SHALL abandon the transfer with no client ack; clients and the SDRAM controller share the same reset.

Structure
REQ-020 The state enum arb_state_t and the default REFRESH_LIMIT SHALL live in m107_pkg.
REQ-021 The design SHALL be a single module with no sub-module; the round-robin select is inline logic.

Verification
REQ-022 Single c0 request: toggle c0_req with c0_addr = 25'h0100040 and sdram returning 64'hDEADBEEF_01234567 after 5 cycles -> sdr_addr = 25'h0100040, sdr_req toggled once, c0_data = 64'hDEADBEEF_01234567, c0_ack toggled 1 cycle after sdr_ack, c1_ack unchanged.
REQ-023 Simultaneous requests: toggle c0_req and c1_req in the same cycle from reset -> c0 served first, then c1; repeat both -> order c0, c1 again (alternation, no starvation).
REQ-024 Forced refresh: hold c0 continuously pending for 600 cycles -> sdr_refresh pulses once shortly after refresh_cnt reaches 512 (after the current BUSY completes), then 4 blocked cycles, then c0 grants resume.
REQ-025 Opportunistic refresh: idle, pulse refresh_hint -> one sdr_refresh pulse next cycle and refresh_cnt = 0; a hint during BUSY -> no pulse.
REQ-026 Reset mid-BUSY: assert reset 2 cycles after a c1 grant -> all outputs return to reset values, and no c1_ack toggle occurs.
